div_iter_param: RTL and testbench
=================================

Name: div_iter_param

Overview:
- Parametrised iterative restoring divider for the CPU's DIV/DIVU path (execute stage to HI/LO); next generation of the fixed 32-bit divider.
- Generalised operand width and bits retired per cycle.
- Adds an ack handshake, divide-by-zero and signed-overflow flags, and a defined divide-by-zero result.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- STEPS, 1, quotient bits retired per clock (1, 2 or 4); WIDTH must be a multiple of STEPS.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start_i  in  1  request; sampled only in IDLE
- signed_i  in  1  1 = two's-complement operands
- cancel_i  in  1  abort current operation
- dividend_i  in  WIDTH  dividend; latched on accepted start
- divisor_i  in  WIDTH  divisor; latched on accepted start
- ack_i  in  1  consumer has taken the result
- busy_o  out  1  high in CALC and FIX
- done_o  out  1  result valid; high only in DONE
- quotient_o  out  WIDTH  quotient
- remainder_o  out  WIDTH  remainder
- div_zero_o  out  1  divisor was zero
- overflow_o  out  1  signed MIN / -1

Behaviour:
- Reset: state = IDLE; all outputs 0. rst asserted in any state aborts the operation the next edge; no done_o.

States:
- IDLE:
  - start_i=1 and cancel_i=0 at edge T latches the operands and signed_i.
  - divisor=0 → DONE.
  - Otherwise → CALC, with |dividend| and |divisor| computed as WIDTH-bit unsigned magnitudes.
  - Signed: magnitude of MIN is 2^(WIDTH-1).
- CALC:
  - N = WIDTH/STEPS cycles; each cycle performs STEPS shift/compare/subtract steps on a (2*WIDTH+1)-bit partial remainder/quotient register.
  - Iteration counter width is $clog2(N+1).
  - → FIX after the last iteration.
- FIX (1 cycle):
  - Quotient is negated if signed_i and the operand signs differ.
  - Remainder is negated if signed_i and the dividend is negative; remainder sign = dividend sign, truncation toward zero.
  - → DONE.
- DONE:
  - quotient_o, remainder_o and the flags are registered on entry and held stable while in DONE; done_o=1.
  - ack_i=1 or cancel_i=1 → IDLE.
  - start_i is ignored until IDLE.

Latency:
- Start accepted at edge T → done_o high from cycle T+N+2; div-by-zero → T+1.
- DONE lasts ≥ 1 cycle even when ack_i is already high.

Results and flags:
- Divide by zero: quotient = all ones, remainder = raw dividend, div_zero_o=1, overflow_o=0.
- Signed MIN / -1: runs the normal path, quotient = MIN, remainder = 0, overflow_o=1.
- Outside DONE: done_o=0; quotient_o, remainder_o and the flags keep their last values.
- cancel_i in CALC/FIX: → IDLE next edge; outputs are not updated.
- cancel_i in IDLE blocks start.
- start_i while busy is ignored, not queued.
- Operand inputs may change freely after acceptance.

Optional Feature:
- Macro: DIV_ITER_EARLY_OUT_EN.
- Defined:
  - In the IDLE accept cycle, compute lz = leading zeros of |dividend|.
  - Pre-shift by floor(lz/STEPS)*STEPS.
  - CALC runs max(1, N - floor(lz/STEPS)) cycles; results are identical.
  - Dividend 0 → CALC runs exactly 1 cycle.
  - Divide-by-zero timing is unchanged.
- Undefined: CALC always takes exactly N cycles, for a fixed latency of N+2.

Test Plan:
- WIDTH=32, STEPS=1, unsigned 100/7 → quotient 14, remainder 2, done_o at T+34, flags 0; ack in the same cycle → IDLE next edge.
- Signed 0xFFFFFFF9 / 0x00000002 (-7/2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Unsigned 5/0 → done_o at T+1, quotient 0xFFFFFFFF, remainder 5, div_zero_o=1. Hold ack_i low 6 cycles → outputs stable and done_o held.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, overflow_o=1. Unsigned same operands → quotient 0, remainder 0x80000000, overflow_o=0.
- Cancel at T+10 → busy_o low at T+11, done_o never asserts, outputs unchanged. Then start 9/3 → quotient 3, remainder 0. Also: rst at T+5 → IDLE with all outputs 0.
- STEPS=2 instance, unsigned 0xFFFFFFFF/0x10 → quotient 0x0FFFFFFF, remainder 0xF, done_o at T+18 (macro off). With the macro on, 0x000000FF/3 → quotient 0x55, remainder 0, done_o at T+6.

Source files
------------

// File: rtl/div_iter_param.sv
// Iterative restoring divider for DIV/DIVU, STEPS quotient bits per clock, with ack handshake.
// Optional early-out pre-shift on dividend leading zeros: define DIV_ITER_EARLY_OUT_EN.
module div_iter_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             overflow_o
);

  localparam int unsigned N  = WIDTH / STEPS;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH:0]   rq_q, rq_d, step_rq;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_load;
  logic               negq_q, negq_d, negr_q, negr_d, ovfp_q, ovfp_d;
  logic [WIDTH-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic               dz_q, dz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag, pre_dvd;

  // MIN stays MIN under negation, which is exactly its 2^(WIDTH-1) magnitude.
  assign dvd_mag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign dvs_mag = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

`ifdef DIV_ITER_EARLY_OUT_EN
  int unsigned lz, skip;
  always_comb begin
    lz = WIDTH;
    for (int i = 0; i < WIDTH; i++) begin
      if (dvd_mag[i]) lz = WIDTH - 1 - i;
    end
    skip     = lz / STEPS;
    pre_dvd  = dvd_mag << (skip * STEPS);
    cnt_load = (skip >= N) ? CW'(1) : CW'(N - skip);
  end
`else
  assign pre_dvd  = dvd_mag;
  assign cnt_load = CW'(N);
`endif

  // Upper WIDTH+1 bits hold the partial remainder, lower WIDTH bits shift in quotient bits.
  always_comb begin
    step_rq = rq_q;
    for (int i = 0; i < STEPS; i++) begin
      step_rq = {step_rq[2*WIDTH-1:0], 1'b0};
      if (step_rq[2*WIDTH:WIDTH] >= {1'b0, dvs_q}) begin
        step_rq[2*WIDTH:WIDTH] = step_rq[2*WIDTH:WIDTH] - {1'b0, dvs_q};
        step_rq[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rq_d    = rq_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    ovfp_d  = ovfp_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !cancel_i) begin
          negq_d = signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
          negr_d = signed_i && dividend_i[WIDTH-1];
          ovfp_d = signed_i && (dividend_i == MinVal) && (divisor_i == '1);
          if (divisor_i == '0) begin
            quot_d  = '1;
            rem_d   = dividend_i;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            state_d = StDone;
          end else begin
            rq_d    = {{(WIDTH+1){1'b0}}, pre_dvd};
            dvs_d   = dvs_mag;
            cnt_d   = cnt_load;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (cancel_i) begin
          state_d = StIdle;
        end else begin
          rq_d  = step_rq;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = StFix;
        end
      end
      StFix: begin
        if (cancel_i) begin
          state_d = StIdle;
        end else begin
          quot_d  = negq_q ? -rq_q[WIDTH-1:0] : rq_q[WIDTH-1:0];
          rem_d   = negr_q ? -rq_q[2*WIDTH-1:WIDTH] : rq_q[2*WIDTH-1:WIDTH];
          dz_d    = 1'b0;
          ovf_d   = ovfp_q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (ack_i || cancel_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rq_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      ovfp_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rq_q    <= rq_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      ovfp_q  <= ovfp_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o      = (state_q == StCalc) || (state_q == StFix);
  assign done_o      = (state_q == StDone);
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dz_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_div_iter_param.sv
// Scoreboard bench for div_iter_param: a STEPS=1 and a STEPS=2 instance at WIDTH=32.
module tb_div_iter_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start0 = 0, signed0 = 0, cancel0 = 0, ack0 = 0;
  logic [31:0] dividend0 = 0, divisor0 = 0;
  logic        busy0, done0, dz0, ov0;
  logic [31:0] quotient0, remainder0;

  logic        start1 = 0, signed1 = 0, cancel1 = 0, ack1 = 0;
  logic [31:0] dividend1 = 0, divisor1 = 0;
  logic        busy1, done1, dz1, ov1;
  logic [31:0] quotient1, remainder1;

  div_iter_param #(.WIDTH(32), .STEPS(1)) u0 (
    .clk(clk), .rst(rst), .start_i(start0), .signed_i(signed0), .cancel_i(cancel0),
    .dividend_i(dividend0), .divisor_i(divisor0), .ack_i(ack0), .busy_o(busy0),
    .done_o(done0), .quotient_o(quotient0), .remainder_o(remainder0),
    .div_zero_o(dz0), .overflow_o(ov0)
  );

  div_iter_param #(.WIDTH(32), .STEPS(2)) u1 (
    .clk(clk), .rst(rst), .start_i(start1), .signed_i(signed1), .cancel_i(cancel1),
    .dividend_i(dividend1), .divisor_i(divisor1), .ack_i(ack1), .busy_o(busy1),
    .done_o(done1), .quotient_o(quotient1), .remainder_o(remainder1),
    .div_zero_o(dz1), .overflow_o(ov1)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          lat;  // edges from the accept edge until done_o is first visible
    int          t;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev0 = 0, prev1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Number of CALC cycles the spec prescribes for a given dividend.
  function automatic int calc_cycles(input logic [31:0] dvd, input logic sgn, input int steps);
    int n;
    n = 32 / steps;
`ifdef DIV_ITER_EARLY_OUT_EN
    begin
      logic [31:0] m;
      int lz, sk;
      m  = (sgn && dvd[31]) ? -dvd : dvd;
      lz = 32;
      for (int i = 31; i >= 0; i--) begin
        if (m[i]) begin
          lz = 31 - i;
          break;
        end
      end
      sk = lz / steps;
      return (sk >= n) ? 1 : n - sk;
    end
`else
    return n;
`endif
  endfunction

  always @(negedge clk) begin
    if (done0 && !prev0) begin
      if (sb0.size() == 0) begin
        chk("u0_unexpected_done", {31'b0, done0}, 32'd0);
      end else begin
        e0 = sb0.pop_front();
        chk("u0_quotient", quotient0, e0.q);
        chk("u0_remainder", remainder0, e0.r);
        chk("u0_div_zero", {31'b0, dz0}, {31'b0, e0.dz});
        chk("u0_overflow", {31'b0, ov0}, {31'b0, e0.ov});
        chk("u0_latency", 32'(cyc - e0.t), 32'(e0.lat));
      end
    end
    prev0 <= done0;
  end

  always @(negedge clk) begin
    if (done1 && !prev1) begin
      if (sb1.size() == 0) begin
        chk("u1_unexpected_done", {31'b0, done1}, 32'd0);
      end else begin
        e1 = sb1.pop_front();
        chk("u1_quotient", quotient1, e1.q);
        chk("u1_remainder", remainder1, e1.r);
        chk("u1_div_zero", {31'b0, dz1}, {31'b0, e1.dz});
        chk("u1_overflow", {31'b0, ov1}, {31'b0, e1.ov});
        chk("u1_latency", 32'(cyc - e1.t), 32'(e1.lat));
      end
    end
    prev1 <= done1;
  end

  // Issue one division, wait (bounded) for done, optionally hold ack low, then ack.
  task automatic issue(input int sel, input logic [31:0] dvd, input logic [31:0] dvs,
                       input logic sgn, input logic [31:0] q, input logic [31:0] r,
                       input logic dz, input logic ov, input int hold, input bit ack_early);
    exp_t e;
    bit   ok;
    logic d;
    @(negedge clk);
    e.q = q; e.r = r; e.dz = dz; e.ov = ov;
    e.t = cyc + 1;
    e.lat = dz ? 0 : calc_cycles(dvd, sgn, sel ? 2 : 1) + 1;
    if (sel == 0) begin
      dividend0 = dvd; divisor0 = dvs; signed0 = sgn; start0 = 1; ack0 = ack_early;
      sb0.push_back(e);
    end else begin
      dividend1 = dvd; divisor1 = dvs; signed1 = sgn; start1 = 1; ack1 = ack_early;
      sb1.push_back(e);
    end
    @(negedge clk);
    start0 = 0; start1 = 0;
    dividend0 = $urandom; divisor0 = $urandom; dividend1 = $urandom; divisor1 = $urandom;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      d = sel ? done1 : done0;
      if (d) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("done_held", {31'b0, (sel ? done1 : done0)}, 32'd1);
        chk("quotient_held", sel ? quotient1 : quotient0, q);
        chk("remainder_held", sel ? remainder1 : remainder0, r);
      end
      if (sel == 0) ack0 = 1; else ack1 = 1;
      @(negedge clk);
      ack0 = 0; ack1 = 0;
      chk("ack_to_idle", {31'b0, (sel ? done1 : done0)}, 32'd0);
    end
  endtask

  initial begin
    int   t;
    bit   saw_done;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_quotient", quotient0, 32'd0);
    chk("rst_remainder", remainder0, 32'd0);
    chk("rst_done_busy", {30'b0, done0, busy0}, 32'd0);
    chk("rst_flags", {30'b0, dz0, ov0}, 32'd0);

    issue(0, 32'd100, 32'd7, 0, 32'd14, 32'd2, 0, 0, 0, 0);
    issue(0, 32'hFFFFFFF9, 32'h2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0, 0);
    issue(0, 32'h7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 32'h1, 0, 0, 0, 0);
    issue(0, 32'hFFFFFF9C, 32'hFFFFFFF9, 1, 32'd14, 32'hFFFFFFFE, 0, 0, 0, 0);
    issue(0, 32'd5, 32'd0, 0, 32'hFFFFFFFF, 32'd5, 1, 0, 6, 0);
    issue(0, 32'hFFFFFFFB, 32'd0, 1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1, 0, 0, 0);
    issue(0, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'h0, 0, 1, 0, 0);
    issue(0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0, 32'h80000000, 0, 0, 0, 0);

    // Cancel mid-CALC: no done, outputs keep the previous result.
    @(negedge clk);
    dividend0 = 32'd100; divisor0 = 32'd7; signed0 = 0; start0 = 1;
    t = cyc + 1;
    @(negedge clk);
    start0 = 0;
    while (cyc < t + 9) @(negedge clk);
    chk("cancel_busy_before", {31'b0, busy0}, 32'd1);
    cancel0 = 1;
    @(negedge clk);
    cancel0 = 0;
    chk("cancel_busy_after", {31'b0, busy0}, 32'd0);
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0) saw_done = 1;
    end
    chk("cancel_no_done", {31'b0, saw_done}, 32'd0);
    chk("cancel_quotient_kept", quotient0, 32'h0);
    chk("cancel_remainder_kept", remainder0, 32'h80000000);

    // ack already high: DONE still lasts one cycle.
    issue(0, 32'd9, 32'd3, 0, 32'd3, 32'd0, 0, 0, 0, 1);

    issue(1, 32'hFFFFFFFF, 32'h10, 0, 32'h0FFFFFFF, 32'hF, 0, 0, 0, 0);
    issue(1, 32'h000000FF, 32'd3, 0, 32'h55, 32'h0, 0, 0, 0, 0);
    issue(1, 32'hFFFFFF9C, 32'h7, 1, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 0, 0, 0);

    // Reset mid-operation clears everything.
    @(negedge clk);
    dividend0 = 32'd100; divisor0 = 32'd7; signed0 = 0; start0 = 1;
    @(negedge clk);
    start0 = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_quotient", quotient0, 32'd0);
    chk("midrst_remainder", remainder0, 32'd0);
    chk("midrst_done_busy", {30'b0, done0, busy0}, 32'd0);
    chk("midrst_flags", {30'b0, dz0, ov0}, 32'd0);
    repeat (40) @(negedge clk);
    chk("midrst_no_done", {31'b0, done0}, 32'd0);

    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    chk("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
